keypad_interface: RTL and testbench
===================================

# keypad_interface

Input conditioning stage that sits directly upstream of `microwave_controller`. It synchronizes and debounces the raw 10-key numeric pad and the three active-low front-panel buttons (start, stop, clear). It drives the controller's `keypad` bus with a clean one-hot level that lasts for the whole press, and rejects multi-key presses. It also produces a one-cycle `key_valid` strobe with a binary `key_code` for any other consumer.

## Interface
- `DEBOUNCE_CYCLES`, 20: consecutive stable synchronized samples required before an input change is accepted (≥2).
- `CNT_W`, 8: debounce counter width; must hold `DEBOUNCE_CYCLES`.

- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `keypad_raw` in 10: raw key lines; bit k = digit k pressed. Asynchronous and bouncy.
- `startn_raw`, `stopn_raw`, `clearn_raw` in 1 each: raw active-low buttons. Asynchronous and bouncy.
- `keypad` out 10: debounced one-hot key level that feeds the controller; 0 when idle.
- `key_code` out 4: binary index (0–9) of the last accepted key.
- `key_valid` out 1: one-cycle strobe when a key press is accepted.
- `key_error` out 1: one-cycle strobe when a stable multi-key pattern is rejected.
- `startn`, `stopn`, `clearn` out 1 each: debounced active-low buttons.

## Operation
- All 13 raw inputs pass through a 2-flop synchronizer. Logic below uses only the synchronized values (`kp_s`, `*_s`).
- Keypad FSM, one shared counter `cnt`:
  - IDLE: `keypad`=0. If `kp_s`≠0, latch `cand`=`kp_s`, set `cnt`=1 and go to DEBOUNCE.
  - DEBOUNCE: if `kp_s`≠`cand`, go to IDLE (no outputs).
    - Otherwise increment `cnt`. When the sample count reaches `DEBOUNCE_CYCLES`:
    - If `cand` is one-hot: `keypad`←`cand`, `key_code`←index, pulse `key_valid`, go to PRESSED.
    - Otherwise: pulse `key_error`, keep `keypad`=0, go to RELEASE.
  - PRESSED: hold `keypad`=`cand`. Any change of `kp_s` (release, or an extra key added) sets `keypad`←0 and `cnt`←0, then goes to RELEASE.
  - RELEASE: `keypad`=0. If `kp_s`==0, increment `cnt`; else set `cnt`←0. After `DEBOUNCE_CYCLES` consecutive zero samples, go to IDLE.
  - A new press can only be accepted from IDLE, so every accepted key needs a full debounced release first.
- Buttons: each has its own counter.
  - If `x_s`==current output, clear the counter.
  - Otherwise increment it. On the `DEBOUNCE_CYCLES`-th consecutive differing sample, toggle the output and clear the counter.
  - Buttons are independent of each other and of the keypad FSM.
- `key_code` holds its value until the next accepted key.
- `key_valid` and `key_error` are never asserted together.
- Counters saturate and never wrap: the FSM leaves the counting state exactly at `DEBOUNCE_CYCLES`.

## Timing
- Reset values: `keypad`=0, `key_code`=0, `key_valid`=0, `key_error`=0, `startn`=`stopn`=`clearn`=1, synchronizer flops = inactive (keys 0, buttons 1), FSM=IDLE, all counters 0.
- Reset acts immediately, including mid-press. After reset deasserts, a key still held is re-debounced from scratch.
- Latency: raw changes before edge 0 and stays stable. The first synchronized sample is taken at edge 2 and the N-th at edge N+1. `keypad`, `key_valid`/`key_error` and button outputs register at edge N+1 (N=`DEBOUNCE_CYCLES`).
- Release: `keypad` drops to 0 at edge 2 after the raw release. No debounce on the falling level, so the controller never sees a stale key.
- A glitch shorter than N cycles during DEBOUNCE or on a button line produces no output change.
- Keypad and button changes on the same edge are processed independently, with no priority between them.

## Test plan
- N=4, `keypad_raw`=10'b00_0000_0010 held 10 cycles then 0:
  - `keypad`=0000000010 registered at edge 5, held through the press, back to 0 two edges after release.
  - `key_valid` high for exactly one cycle; `key_code`=1.
- N=4, key 4 pulsed for 2 cycles, low 2, high 2, then held: no output during the bounce; `key_valid` fires exactly once, 5 edges after the final stable edge; `key_code`=4.
- N=4, `keypad_raw`=10'b00_0000_0011 held:
  - `key_error` pulses once at edge 5; `keypad` stays 0; `key_valid` stays 0.
  - After release plus 4 zero samples, a following press of key 0 gives `key_code`=0.
- N=4, `startn_raw` low for 3 cycles: `startn` stays 1. `startn_raw` held low: `startn`=0 at edge 5. Raising it gives `startn`=1 at edge 5 after the rise.
- N=4, reset asserted while in PRESSED with key 7:
  - All outputs go to reset values without waiting for a clock edge.
  - After deassert, key 7 still held yields a fresh `key_valid` after 6 edges.
- N=4, key 2 released and key 9 pressed after only 2 zero cycles: no acceptance until 4 zero samples and a full key-9 debounce; then `key_code`=9.

Source files
------------

// File: rtl/keypad_interface_if.sv
// Raw keypad/button lines toward the conditioner, clean key level, strobes and buttons back.
// master drives the raw lines; slave is the conditioning stage.
interface keypad_interface_if;
   logic [9:0] keypad_raw;
   logic       startn_raw;
   logic       stopn_raw;
   logic       clearn_raw;
   logic [9:0] keypad;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_error;
   logic       startn;
   logic       stopn;
   logic       clearn;

   modport master (
      output keypad_raw, startn_raw, stopn_raw, clearn_raw,
      input  keypad, key_code, key_valid, key_error, startn, stopn, clearn
   );

   modport slave (
      input  keypad_raw, startn_raw, stopn_raw, clearn_raw,
      output keypad, key_code, key_valid, key_error, startn, stopn, clearn
   );
endinterface

// File: rtl/keypad_interface.sv
// Synchronizes and debounces the 10-key pad (one-hot level, multi-key rejection) and three active-low buttons.
// Latency DEBOUNCE_CYCLES+2 edges from a stable raw change; key release clears keypad after 2 edges; no backpressure.
module keypad_interface #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int CNT_W           = 8
) (
   input  logic               clock,
   input  logic               reset,
   keypad_interface_if.slave  kif
);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [9:0]       kp_s1_q, kp_s_q;
   logic [2:0]       btn_s1_q, btn_s_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       cand_q, cand_d;
   logic [9:0]       keypad_q, keypad_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_error_q, key_error_d;
   logic [2:0]       btn_out_q, btn_out_d;
   logic [CNT_W-1:0] btn_cnt_q [3];
   logic [CNT_W-1:0] btn_cnt_d [3];
   logic [3:0]       cand_idx;

   always_comb begin
      cand_idx = '0;
      for (int i = 0; i < 10; i++) begin
         if (cand_q[i]) cand_idx = 4'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      keypad_d    = keypad_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            keypad_d = '0;
            if (kp_s_q != '0) begin
               cand_d  = kp_s_q;
               cnt_d   = CNT_ONE;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (kp_s_q != cand_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if ($onehot(cand_q)) begin
                  keypad_d    = cand_q;
                  key_code_d  = cand_idx;
                  key_valid_d = 1'b1;
                  state_d     = PRESSED;
               end else begin
                  key_error_d = 1'b1;
                  state_d     = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            // Any change, including an added key, drops the level with no debounce.
            if (kp_s_q != cand_q) begin
               keypad_d = '0;
               cnt_d    = '0;
               state_d  = RELEASE;
            end
         end
         RELEASE: begin
            keypad_d = '0;
            if (kp_s_q != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int b = 0; b < 3; b++) begin
         btn_out_d[b] = btn_out_q[b];
         btn_cnt_d[b] = btn_cnt_q[b];
         if (btn_s_q[b] == btn_out_q[b]) begin
            btn_cnt_d[b] = '0;
         end else if (btn_cnt_q[b] == CNT_LAST) begin
            btn_out_d[b] = ~btn_out_q[b];
            btn_cnt_d[b] = '0;
         end else begin
            btn_cnt_d[b] = btn_cnt_q[b] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         kp_s1_q     <= '0;
         kp_s_q      <= '0;
         btn_s1_q    <= 3'b111;
         btn_s_q     <= 3'b111;
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= '0;
         keypad_q    <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_error_q <= 1'b0;
         btn_out_q   <= 3'b111;
         for (int b = 0; b < 3; b++) btn_cnt_q[b] <= '0;
      end else begin
         kp_s1_q     <= kif.keypad_raw;
         kp_s_q      <= kp_s1_q;
         btn_s1_q    <= {kif.startn_raw, kif.stopn_raw, kif.clearn_raw};
         btn_s_q     <= btn_s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         keypad_q    <= keypad_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_error_q <= key_error_d;
         btn_out_q   <= btn_out_d;
         for (int b = 0; b < 3; b++) btn_cnt_q[b] <= btn_cnt_d[b];
      end
   end

   assign kif.keypad    = keypad_q;
   assign kif.key_code  = key_code_q;
   assign kif.key_valid = key_valid_q;
   assign kif.key_error = key_error_q;
   assign kif.startn    = btn_out_q[2];
   assign kif.stopn     = btn_out_q[1];
   assign kif.clearn    = btn_out_q[0];
endmodule

// File: tb/tb_keypad_interface.sv
// Random and scripted keypad/button stimulus checked every edge against a sample-history reference model.
module tb_keypad_interface;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   keypad_interface_if kif();

   keypad_interface #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .kif   (kif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: keeps every synchronized sample since reset and decides
   // acceptance from windows over that history.
   logic [9:0] m_kp1, m_kp2;
   logic [2:0] m_bt1, m_bt2;
   logic [9:0] ksmp[$];
   logic [2:0] bsmp[$];
   int         cand_at, quiet_from;
   bit         held;
   logic [9:0] held_v;
   logic [9:0] e_keypad;
   logic [3:0] e_code;
   logic       e_valid, e_error;
   logic [2:0] e_btn;

   function automatic logic [3:0] index_of(input logic [9:0] v);
      index_of = '0;
      for (int i = 0; i < 10; i++) if (v == (10'd1 << i)) index_of = 4'(i);
   endfunction

   task automatic model_reset();
      m_kp1 = '0; m_kp2 = '0;
      m_bt1 = 3'b111; m_bt2 = 3'b111;
      ksmp.delete(); bsmp.delete();
      cand_at = -1; quiet_from = -1; held = 0; held_v = '0;
      e_keypad = '0; e_code = '0; e_valid = 0; e_error = 0; e_btn = 3'b111;
   endtask

   task automatic model_edge();
      logic [9:0] v;
      logic [2:0] bv;
      int t;
      bit all;
      v = m_kp2; bv = m_bt2;
      m_kp2 = m_kp1; m_bt2 = m_bt1;
      m_kp1 = kif.keypad_raw;
      m_bt1 = {kif.startn_raw, kif.stopn_raw, kif.clearn_raw};

      ksmp.push_back(v);
      t = ksmp.size() - 1;
      e_valid = 0; e_error = 0;
      if (held) begin
         if (v != held_v) begin
            held = 0; e_keypad = '0; quiet_from = t + 1;
         end
      end else if (quiet_from >= 0) begin
         if (t - N + 1 >= quiet_from) begin
            all = 1;
            for (int j = 0; j < N; j++) if (ksmp[t-j] != '0) all = 0;
            if (all) quiet_from = -1;
         end
      end else if (cand_at >= 0) begin
         if (v != ksmp[cand_at]) begin
            cand_at = -1;
         end else if (t - cand_at + 1 == N) begin
            if ($countones(v) == 1) begin
               e_keypad = v; e_code = index_of(v); e_valid = 1;
               held = 1; held_v = v;
            end else begin
               e_error = 1; quiet_from = t + 1;
            end
            cand_at = -1;
         end
      end else if (v != '0) begin
         cand_at = t;
      end

      bsmp.push_back(bv);
      t = bsmp.size() - 1;
      if (t + 1 >= N) begin
         for (int b = 0; b < 3; b++) begin
            all = 1;
            for (int j = 0; j < N; j++) if (bsmp[t-j][b] == e_btn[b]) all = 0;
            if (all) e_btn[b] = ~e_btn[b];
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".keypad"},    32'(kif.keypad),    32'(e_keypad));
      check({ph, ".key_code"},  32'(kif.key_code),  32'(e_code));
      check({ph, ".key_valid"}, 32'(kif.key_valid), 32'(e_valid));
      check({ph, ".key_error"}, 32'(kif.key_error), 32'(e_error));
      check({ph, ".startn"},    32'(kif.startn),    32'(e_btn[2]));
      check({ph, ".stopn"},     32'(kif.stopn),     32'(e_btn[1]));
      check({ph, ".clearn"},    32'(kif.clearn),    32'(e_btn[0]));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      model_edge();
      compare_all("run");
   endtask

   task automatic hold(input logic [9:0] kp, input logic [2:0] bt, input int cyc);
      kif.keypad_raw = kp;
      {kif.startn_raw, kif.stopn_raw, kif.clearn_raw} = bt;
      repeat (cyc) step();
   endtask

   // Reset is applied between edges so its effect is checked before any clock.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("rst_async");
      @(posedge clock);
      @(posedge clock);
      #1;
      compare_all("rst_hold");
      reset = 1'b0;
   endtask

   logic [2:0] bt_r;
   logic [9:0] kp_r;
   int         sel;

   initial begin
      kif.keypad_raw = '0;
      kif.startn_raw = 1'b1;
      kif.stopn_raw  = 1'b1;
      kif.clearn_raw = 1'b1;
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      compare_all("reset");
      reset = 1'b0;

      hold(10'b00_0000_0010, 3'b111, 10);
      hold('0, 3'b111, 8);

      hold(10'd1 << 4, 3'b111, 2);
      hold('0, 3'b111, 2);
      hold(10'd1 << 4, 3'b111, 2);
      hold(10'd1 << 4, 3'b111, 12);
      hold('0, 3'b111, 8);

      hold(10'b00_0000_0011, 3'b111, 8);
      hold('0, 3'b111, 8);
      hold(10'b00_0000_0001, 3'b111, 8);
      hold('0, 3'b111, 8);

      hold('0, 3'b011, 3);
      hold('0, 3'b111, 6);
      hold('0, 3'b011, 8);
      hold('0, 3'b111, 8);

      hold(10'd1 << 7, 3'b111, 10);
      do_reset();
      hold(10'd1 << 7, 3'b111, 10);
      hold('0, 3'b111, 8);

      hold(10'd1 << 2, 3'b111, 10);
      hold('0, 3'b111, 2);
      hold(10'd1 << 9, 3'b111, 14);
      hold('0, 3'b111, 8);

      bt_r = 3'b111;
      for (int s = 0; s < 450; s++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4)       kp_r = '0;
         else if (sel < 8)  kp_r = 10'd1 << $urandom_range(0, 9);
         else if (sel == 8) kp_r = (10'd1 << $urandom_range(0, 4)) | (10'd1 << $urandom_range(5, 9));
         else               kp_r = 10'($urandom);
         if ($urandom_range(0, 2) == 0) bt_r = bt_r ^ 3'($urandom_range(1, 7));
         hold(kp_r, bt_r, $urandom_range(1, 10));
         if ($urandom_range(0, 59) == 0) do_reset();
      end
      hold('0, 3'b111, 12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
